// File: rtl/wb_timer_pkg.sv
// Shared constants for the Wishbone timer: register word indices, bit positions
// and the byte-lane write helper.
package wb_timer_pkg;

   localparam logic [2:0] IDX_CTRL   = 3'd0;
   localparam logic [2:0] IDX_LOAD   = 3'd1;
   localparam logic [2:0] IDX_COUNT  = 3'd2;
   localparam logic [2:0] IDX_STATUS = 3'd3;
   localparam logic [2:0] IDX_PRESC  = 3'd4;
   localparam logic [2:0] IDX_LAST   = IDX_PRESC;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_IE     = 2;
   localparam int CTRL_W      = 3;
   localparam int STATUS_PEND = 0;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_timer_single_prescaler.sv
// Clock prescaler: counts 0..presc while enabled and pulses tick on the cycle
// the count equals presc.
module timer_prescaler #(
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          restart_i,
   input  logic [PW-1:0] presc_i,
   output logic          tick_o
);

   logic [PW-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == presc_i);

   always_comb begin
      cnt_d = cnt_q + PW'(1);
      if (!en_i || restart_i || tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/wb_timer_single.sv
// 32-bit Wishbone slave down-counter timer with prescaler, reload/one-shot
// modes and a registered level interrupt.
module wb_timer_single
   import wb_timer_pkg::*;
#(
   parameter int MSK = 24,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int PW  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   i_wb_adr,
   input  logic [DW/8-1:0] i_wb_sel,
   input  logic            i_wb_we,
   input  logic [DW-1:0]   i_wb_dat,
   output logic [DW-1:0]   o_wb_dat,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   output logic            o_wb_ack,
   output logic            o_wb_err,
   output logic            o_irq
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DW-1:0]     load_q, load_d, count_q, count_d, dat_q, rdata;
   logic [PW-1:0]     presc_q, presc_d;
   logic              pend_q, pend_d, ack_q, err_q, irq_q;
   logic              access, mapped, wr_en, presc_wr, tick, expire;
   logic [2:0]        idx;
   logic              unused_adr;

   assign idx        = i_wb_adr[4:2];
   assign access     = i_wb_cyc & i_wb_stb & ~ack_q & ~err_q;
   assign mapped     = (i_wb_adr[MSK-1:5] == '0) && (idx <= IDX_LAST);
   assign wr_en      = access & mapped & i_wb_we;
   assign presc_wr   = wr_en && (idx == IDX_PRESC);
   assign expire     = tick && (count_q == '0);
   // Bits above the local window are decoded by the crossbar; [1:0] are lane bits.
   assign unused_adr = ^{i_wb_adr[AW-1:MSK], i_wb_adr[1:0]};

   timer_prescaler #(.PW(PW)) u_presc (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (ctrl_q[CTRL_EN]),
      .restart_i (presc_wr),
      .presc_i   (presc_q),
      .tick_o    (tick)
   );

   always_comb begin
      // NOTE: every next-state value gets a default first so no path can infer a latch.
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      pend_d  = pend_q;
      presc_d = presc_q;
      if (tick) begin
         if (!expire)                  count_d = count_q - 32'd1;
         else if (ctrl_q[CTRL_RELOAD]) count_d = load_q;
         else                          ctrl_d[CTRL_EN] = 1'b0;
      end
      if (wr_en) begin
         case (idx)
            IDX_CTRL:   ctrl_d  = CTRL_W'(merge_bytes(32'(ctrl_d), i_wb_dat, i_wb_sel));
            IDX_LOAD:   load_d  = merge_bytes(load_q, i_wb_dat, i_wb_sel);
            IDX_COUNT:  count_d = merge_bytes(count_d, i_wb_dat, i_wb_sel);
            IDX_STATUS: if (i_wb_sel[0] && i_wb_dat[STATUS_PEND]) pend_d = 1'b0;
            IDX_PRESC:  presc_d = PW'(merge_bytes(32'(presc_q), i_wb_dat, i_wb_sel));
            default: ;
         endcase
      end
      // Expiry is applied last so it beats a same-cycle write-1-to-clear.
      if (expire) pend_d = 1'b1;
   end

   always_comb begin
      rdata = '0;
      case (idx)
         IDX_CTRL:   rdata = 32'(ctrl_q);
         IDX_LOAD:   rdata = load_q;
         IDX_COUNT:  rdata = count_q;
         IDX_STATUS: rdata = 32'(pend_q);
         IDX_PRESC:  rdata = 32'(presc_q);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= '0;
         load_q  <= '0;
         count_q <= '0;
         pend_q  <= 1'b0;
         presc_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         ctrl_q  <= ctrl_d;
         load_q  <= load_d;
         count_q <= count_d;
         pend_q  <= pend_d;
         presc_q <= presc_d;
         ack_q   <= access & mapped;
         err_q   <= access & ~mapped;
         dat_q   <= (access && mapped && !i_wb_we) ? rdata : '0;
         irq_q   <= pend_q & ctrl_q[CTRL_IE];
      end
   end

   assign o_wb_ack = ack_q;
   assign o_wb_err = err_q;
   assign o_wb_dat = dat_q;
   assign o_irq    = irq_q;

endmodule

// File: tb/tb_wb_timer_single.sv
// Scoreboard bench for wb_timer_single: a clock-level behavioural model predicts
// every bus response and the interrupt level; a monitor compares at negedge.
`timescale 1ns/1ps
module tb_wb_timer_single;

   localparam logic [31:0] A_CTRL = 32'h00, A_LOAD = 32'h04, A_COUNT = 32'h08,
                           A_STATUS = 32'h0C, A_PRESC = 32'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wb_adr = '0, wb_dat_w = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
   logic [31:0] o_wb_dat;
   logic        o_wb_ack, o_wb_err, o_irq;

   always #5 clk = ~clk;

   wb_timer_single #(.MSK(24), .AW(32), .DW(32), .PW(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wb_adr (wb_adr),
      .i_wb_sel (wb_sel),
      .i_wb_we  (wb_we),
      .i_wb_dat (wb_dat_w),
      .o_wb_dat (o_wb_dat),
      .i_wb_cyc (wb_cyc),
      .i_wb_stb (wb_stb),
      .o_wb_ack (o_wb_ack),
      .o_wb_err (o_wb_err),
      .o_irq    (o_irq)
   );

   typedef struct packed { logic err; logic [31:0] data; } resp_t;
   resp_t exp_q[$];
   int    n_cmp = 0, n_bad = 0;
   int    cyc_cnt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   bit          m_en, m_reload, m_ie, m_pend, m_busy, m_irq;
   int unsigned m_load, m_count, m_presc, m_phase;
   logic        ovr_use = 1'b0;
   logic [31:0] ovr_val = '0;

   bit          t_tick, t_acc, t_hit, t_set, t_clr, n_en, n_reload, n_ie;
   int unsigned t_off, t_idx, n_count, n_phase, n_presc, n_load;
   resp_t       t_resp;

   function automatic int unsigned lanes(int unsigned old_v, int unsigned new_v, logic [3:0] sel);
      int unsigned r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r = (r & ~(32'hFF << (8*b))) | (new_v & (32'hFF << (8*b)));
      end
      return r;
   endfunction

   function automatic logic [31:0] m_read(int unsigned idx);
      case (idx)
         0: return {29'd0, m_ie, m_reload, m_en};
         1: return m_load;
         2: return m_count;
         3: return {31'd0, m_pend};
         default: return m_presc;
      endcase
   endfunction

   always @(posedge clk) cyc_cnt++;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en = 0; m_reload = 0; m_ie = 0; m_pend = 0; m_busy = 0; m_irq = 0;
         m_load = 0; m_count = 0; m_presc = 0; m_phase = 0;
         exp_q.delete();
      end else begin
         t_tick = m_en && (m_phase == m_presc);
         t_acc  = wb_cyc && wb_stb && !m_busy;
         t_off  = wb_adr & 32'h00FF_FFFF;
         t_idx  = (t_off >> 2) & 7;
         t_hit  = t_acc && ((t_off >> 5) == 0) && (t_idx <= 4);
         if (t_acc) begin
            t_resp.err  = !t_hit;
            t_resp.data = (t_hit && !wb_we) ? (ovr_use ? ovr_val : m_read(t_idx)) : 32'h0;
            exp_q.push_back(t_resp);
         end
         n_en = m_en; n_reload = m_reload; n_ie = m_ie;
         n_count = m_count; n_load = m_load; n_presc = m_presc;
         t_set = 0; t_clr = 0;
         if (t_tick) begin
            if (m_count != 0) n_count = m_count - 1;
            else begin
               t_set = 1;
               if (m_reload) n_count = m_load;
               else          n_en = 0;
            end
         end
         n_phase = (!m_en || t_tick) ? 0 : m_phase + 1;
         if (t_hit && wb_we) begin
            case (t_idx)
               0: if (wb_sel[0]) begin n_en = wb_dat_w[0]; n_reload = wb_dat_w[1]; n_ie = wb_dat_w[2]; end
               1: n_load = lanes(m_load, wb_dat_w, wb_sel);
               2: n_count = lanes(n_count, wb_dat_w, wb_sel);
               3: t_clr = wb_sel[0] && wb_dat_w[0];
               default: begin n_presc = lanes(m_presc, wb_dat_w, wb_sel) & 32'hFFFF; n_phase = 0; end
            endcase
         end
         m_irq   = m_pend && m_ie;
         m_pend  = t_set ? 1'b1 : (t_clr ? 1'b0 : m_pend);
         m_en    = n_en; m_reload = n_reload; m_ie = n_ie;
         m_count = n_count; m_load = n_load; m_presc = n_presc; m_phase = n_phase;
         m_busy  = t_acc;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("resp_valid", 32'(o_wb_ack | o_wb_err), 32'(m_busy));
         check("ack_err_excl", 32'(o_wb_ack & o_wb_err), 32'h0);
         if (o_wb_ack || o_wb_err) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_resp: ack=%0b err=%0b with no expected response", o_wb_ack, o_wb_err);
            end else begin
               t_resp = exp_q.pop_front();
               check("resp_err", 32'(o_wb_err), 32'(t_resp.err));
               check("rdata", o_wb_dat, t_resp.data);
            end
         end
         check("irq", 32'(o_irq), 32'(m_irq));
      end
   end

   // ---------------- stimulus (all tasks entered at a negedge) ----------------
   task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic use_c, input logic [31:0] cval);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
      ovr_use = use_c; ovr_val = cval;
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; ovr_use = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      bus(1'b1, adr, dat, 4'hF, 1'b0, 32'h0);
   endtask

   task automatic rd_c(input logic [31:0] adr, input logic [31:0] exp);
      bus(1'b0, adr, 32'h0, 4'hF, 1'b1, exp);
   endtask

   // Stops on the negedge before a tick edge whose COUNT zero-ness matches want_zero.
   task automatic wait_tick(input bit want_zero, output bit ok);
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (m_en && (m_phase == m_presc) && ((m_count == 0) == want_zero)) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) fail_now("wait_tick");
   endtask

   task automatic wait_irq_rise(output int t, output bit ok);
      bit prev = o_irq;
      ok = 0;
      t  = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_irq && !prev) begin
            ok = 1;
            t  = cyc_cnt;
            break;
         end
         prev = o_irq;
      end
      if (!ok) fail_now("irq_rise");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int t0, t1;
      logic [31:0] adr, dat;

      repeat (2) @(negedge clk);
      check("rst_ack", 32'(o_wb_ack), 32'h0);
      check("rst_err", 32'(o_wb_err), 32'h0);
      check("rst_irq", 32'(o_irq), 32'h0);
      check("rst_dat", o_wb_dat, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      rd_c(A_CTRL, 0); rd_c(A_LOAD, 0); rd_c(A_COUNT, 0); rd_c(A_STATUS, 0); rd_c(A_PRESC, 0);

      // Byte lanes
      wr(A_LOAD, 32'h0);
      bus(1'b1, A_LOAD, 32'hAABB_CCDD, 4'b0010, 1'b0, 32'h0);
      rd_c(A_LOAD, 32'h0000_CC00);

      // Unmapped offsets: err, nothing changes (0x100 would alias CTRL if decoded short)
      bus(1'b0, 32'h14, 32'h0, 4'hF, 1'b0, 32'h0);
      bus(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
      rd_c(A_CTRL, 32'h0);
      rd_c(A_LOAD, 32'h0000_CC00);

      // Periodic: (3+1)*(1+1) = 8 clocks between expiries
      wr(A_PRESC, 1); wr(A_LOAD, 3); wr(A_COUNT, 0); wr(A_STATUS, 1); wr(A_CTRL, 7);
      wait_irq_rise(t0, ok);
      for (int k = 0; k < 3; k++) begin
         wr(A_STATUS, 1);
         check("irq_drop_after_w1c", 32'(o_irq), 32'h0);
         wait_irq_rise(t1, ok);
         check("period", t1 - t0, 8);
         t0 = t1;
      end

      // One-shot: COUNT 2 -> expires on the third tick, EN self-clears
      wr(A_CTRL, 0); wr(A_PRESC, 0); wr(A_STATUS, 1); wr(A_LOAD, 2); wr(A_COUNT, 2);
      wr(A_CTRL, 1);
      repeat (8) @(negedge clk);
      rd_c(A_CTRL, 32'h0); rd_c(A_COUNT, 32'h0); rd_c(A_STATUS, 32'h1);

      // Collision: W1C on the expiry edge leaves PEND set
      wr(A_PRESC, 3); wr(A_LOAD, 2); wr(A_COUNT, 0); wr(A_CTRL, 3);
      repeat (3) @(negedge clk);
      wr(A_STATUS, 1);
      wait_tick(1'b1, ok);
      if (ok) begin
         wr(A_STATUS, 1);
         rd_c(A_STATUS, 32'h1);
      end

      // Collision: COUNT write on a decrementing tick edge wins
      wr(A_CTRL, 0); wr(A_PRESC, 10); wr(A_LOAD, 100); wr(A_COUNT, 50); wr(A_CTRL, 3);
      wait_tick(1'b0, ok);
      if (ok) begin
         wr(A_COUNT, 5);
         rd_c(A_COUNT, 32'h5);
      end

      // Randomized traffic checked by the model
      wr(A_CTRL, 0); wr(A_PRESC, 1); wr(A_LOAD, 4);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 9) adr = 32'h100 | ($urandom_range(0, 7) << 2);
         else                           adr = $urandom_range(0, 5) << 2;
         if ($urandom_range(0, 4) == 0) adr = adr | ($urandom & 32'hFF00_0000);
         dat = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
         bus(1'($urandom_range(0, 1)), adr, dat, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Async reset before the accept edge: the write must not land
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = A_LOAD; wb_dat_w = 32'h55; wb_sel = 4'hF;
      #2 rst_n = 1'b0;
      #1 check("rst_mid_write_ack", 32'(o_wb_ack), 32'h0);
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      rd_c(A_LOAD, 32'h0);
      // Async reset while ack is high drops it at once
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_CTRL;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_mid_ack", 32'(o_wb_ack), 32'h0);
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      rd_c(A_COUNT, 32'h0); rd_c(A_STATUS, 32'h0); rd_c(A_PRESC, 32'h0);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
